// File: rtl/rom_loadable.sv
// rom_loadable: byte-wide boot ROM whose image is streamed in by a loader
// over a valid/ready interface, tail-padded with FILL, then served as a
// synchronous read-only memory.
//
// Optional checksum outputs (csum, csum_ok) are built when the macro
// ROM_LOADABLE_CHECKSUM_EN is defined; the default build omits them.
module rom_loadable #(
    parameter int         KB    = 16,
    parameter logic [7:0] FILL  = 8'hFF,
    localparam int        DEPTH = KB * 1024,
    localparam int        AW    = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          reload,
    output logic          busy,
    input  logic [AW-1:0] a,
    output logic [7:0]    q
`ifdef ROM_LOADABLE_CHECKSUM_EN
    ,
    output logic [7:0]    csum,
    output logic          csum_ok
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FILL,
        ST_RUN
    } state_t;

    // Address of the final location; reaching it ends LOAD or FILL.
    localparam logic [AW:0] LAST_ADDR = (AW + 1)'(DEPTH - 1);

    state_t      state;
    logic [AW:0] cnt;       // one spare bit, never wraps in normal use
    logic        accept;
    logic        at_top;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [AW-1:0] wr_addr;

    logic [7:0]  mem [DEPTH];

    assign accept = ld_valid & ld_ready;
    assign at_top = (cnt == LAST_ADDR);
    assign busy   = (state != ST_RUN);

    // Write port source: loader bytes in LOAD, pad value in FILL.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = ld_data;
        wr_addr = cnt[AW-1:0];
        if (state == ST_LOAD && accept) begin
            wr_en = 1'b1;
        end else if (state == ST_FILL) begin
            wr_en   = 1'b1;
            wr_data = FILL;
        end
    end

    // Sequencer: LOAD accepts the stream, FILL pads the tail, RUN serves reads.
    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_LOAD;
            cnt      <= '0;
            ld_ready <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    ld_ready <= 1'b1;
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (at_top) begin
                            state    <= ST_RUN;
                            ld_ready <= 1'b0;
                        end else if (ld_last) begin
                            state    <= ST_FILL;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                ST_FILL: begin
                    ld_ready <= 1'b0;
                    cnt      <= cnt + 1'b1;
                    if (at_top) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    ld_ready <= 1'b0;
                    if (reload) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state    <= ST_LOAD;
                    cnt      <= '0;
                    ld_ready <= 1'b0;
                end
            endcase
        end
    end

    // Image storage write port.
    // NOTE: the array has no reset so it maps onto block RAM; its contents
    // deliberately survive a reset and are simply overwritten by the next load.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; the image is hidden behind FILL until RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= FILL;
        end else if (busy) begin
            q <= FILL;
        end else begin
            q <= mem[a];
        end
    end

`ifdef ROM_LOADABLE_CHECKSUM_EN
    logic [7:0] csum_next;

    assign csum_next = csum + ld_data;

    // Running mod-256 sum of loader bytes; verdict latched on entry to RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum    <= 8'h00;
            csum_ok <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: begin
                    if (accept) begin
                        csum <= csum_next;
                        if (at_top) begin
                            csum_ok <= (csum_next == 8'h00);
                        end
                    end
                end
                ST_FILL: begin
                    if (at_top) begin
                        csum_ok <= (csum == 8'h00);
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        csum    <= 8'h00;
                        csum_ok <= 1'b0;
                    end
                end
                default: begin
                    csum    <= 8'h00;
                    csum_ok <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rom_loadable.sv
// tb_rom_loadable: self-checking bench for rom_loadable (KB=1).
// Read expectations go through a scoreboard queue: pushed when an address
// is driven, popped when q is sampled one cycle later.
module tb_rom_loadable;

    localparam int         DEPTH      = 1024;
    localparam int         AW         = 10;
    localparam logic [7:0] FILL       = 8'hFF;
    localparam int         LOAD_LIMIT = 8000;
    localparam int         FILL_LIMIT = 3000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = 8'h00;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          reload = 1'b0;
    logic          busy;
    logic [AW-1:0] a = '0;
    logic [7:0]    q;
`ifdef ROM_LOADABLE_CHECKSUM_EN
    logic [7:0]    csum;
    logic          csum_ok;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] img     [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    logic [7:0] sb      [$];
    logic [7:0] exp_sum;

    rom_loadable #(.KB(1), .FILL(FILL)) dut (
        .clock    (clock),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .reload   (reload),
        .busy     (busy),
        .a        (a),
        .q        (q)
`ifdef ROM_LOADABLE_CHECKSUM_EN
        ,
        .csum     (csum),
        .csum_ok  (csum_ok)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream img[0..n-1]; each accepted byte also updates the model image.
    task automatic load_image(input string tag, input int n, input bit rnd, input bit use_last);
        int idx;
        int guard;
        idx     = 0;
        guard   = 0;
        exp_sum = 8'h00;
        while (idx < n && guard < LOAD_LIMIT) begin
            @(negedge clock);
            guard++;
            ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = img[idx];
            ld_last  = use_last && (idx == n - 1);
            if (ld_valid && ld_ready) begin
                if (idx == n - 1) check({tag, "_busy_before_last"}, busy, 1);
                exp_mem[idx] = img[idx];
                exp_sum      = exp_sum + img[idx];
                idx++;
            end
        end
        @(negedge clock);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check({tag, "_accepted"}, idx, n);
    endtask

    task automatic read_one(input string tag, input int addr, input logic [7:0] exp);
        @(negedge clock);
        a = AW'(addr);
        sb.push_back(exp);
        @(negedge clock);
        check(tag, q, sb.pop_front());
    endtask

    // Pipelined sweep: a new address every cycle, results one cycle behind.
    task automatic read_all(input string tag);
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clock);
            if (i > 0) check(tag, q, sb.pop_front());
            if (i < DEPTH) begin
                a = AW'(i);
                sb.push_back(exp_mem[i]);
            end
        end
    endtask

    task automatic do_reload(input string tag);
        @(negedge clock);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_lo"}, ld_ready, 0);
`ifdef ROM_LOADABLE_CHECKSUM_EN
        check({tag, "_csum_clr"}, csum, 0);
        check({tag, "_csum_ok_clr"}, csum_ok, 0);
`endif
        @(negedge clock);
        check({tag, "_ready_hi"}, ld_ready, 1);
    endtask

    task automatic wait_fill(input string tag, input int start, input int exp_cycles);
        int cycles;
        cycles = start;
        while (busy && cycles < FILL_LIMIT) begin
            @(negedge clock);
            cycles++;
        end
        check({tag, "_fill_cycles"}, cycles, exp_cycles);
    endtask

    initial begin
        // Reset state.
        #12;
        check("rst_q", q, FILL);
        check("rst_busy", busy, 1);
        check("rst_ready", ld_ready, 0);
`ifdef ROM_LOADABLE_CHECKSUM_EN
        check("rst_csum", csum, 0);
        check("rst_csum_ok", csum_ok, 0);
`endif
        @(negedge clock);
        reset = 1'b1;
        check("rel_ready_still_lo", ld_ready, 0);
        @(negedge clock);
        check("rel_ready_hi", ld_ready, 1);

        // Full continuous load, data = addr[7:0].
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        load_image("full", DEPTH, 1'b0, 1'b0);
        check("full_busy_lo", busy, 0);
        check("full_ready_lo", ld_ready, 0);
        read_one("full_a000", 'h000, 8'h00);
        read_one("full_a1ff", 'h1FF, 8'hFF);
        read_one("full_a3ff", 'h3FF, 8'hFF);
        read_all("full_img");
`ifdef ROM_LOADABLE_CHECKSUM_EN
        check("full_csum", csum, exp_sum);
        check("full_csum_ok", csum_ok, exp_sum == 8'h00);
`endif

        // Short image with ld_last, tail padding; reload during FILL ignored.
        do_reload("rl1");
        read_one("busy_read_a5", 5, FILL);
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        load_image("short", 4, 1'b0, 1'b1);
        check("short_ready_lo", ld_ready, 0);
        check("short_busy_hi", busy, 1);
        reload = 1'b1;
        @(negedge clock);
        reload = 1'b0;
        wait_fill("short", 1, 1020);
        for (int i = 4; i < DEPTH; i++) exp_mem[i] = FILL;
        read_one("short_a3", 3, 8'h44);
        read_one("short_a4", 4, 8'hFF);
        read_one("short_a3ff", 'h3FF, 8'hFF);
        read_one("short_a0", 0, 8'h11);
`ifdef ROM_LOADABLE_CHECKSUM_EN
        check("short_csum", csum, 8'hAA);
        check("short_csum_ok", csum_ok, 0);
`endif

        // Random data, random ld_valid gaps, ld_last on the final location.
        do_reload("rl2");
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        img[5] = 8'hA5;
        load_image("rnd", DEPTH, 1'b1, 1'b1);
        check("rnd_busy_lo", busy, 0);
        read_one("rnd_a5", 5, 8'hA5);
        read_all("rnd_img");
`ifdef ROM_LOADABLE_CHECKSUM_EN
        check("rnd_csum", csum, exp_sum);
        check("rnd_csum_ok", csum_ok, exp_sum == 8'h00);
`endif

        // Reset part way through FILL aborts; a fresh load then works.
        do_reload("rl3");
        img[0] = 8'h5A; img[1] = 8'hC3;
        load_image("abort", 2, 1'b0, 1'b1);
        for (int i = 0; i < 98; i++) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("abort_q", q, FILL);
        check("abort_busy", busy, 1);
        check("abort_ready", ld_ready, 0);
`ifdef ROM_LOADABLE_CHECKSUM_EN
        check("abort_csum", csum, 0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        check("abort_rel_ready_lo", ld_ready, 0);
        @(negedge clock);
        check("abort_rel_ready_hi", ld_ready, 1);
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
        load_image("fresh", DEPTH, 1'b0, 1'b0);
        check("fresh_busy_lo", busy, 0);
        read_all("fresh_img");

`ifdef ROM_LOADABLE_CHECKSUM_EN
        // Checksum pass and fail images.
        do_reload("rl4");
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'hFA;
        load_image("cs_good", 4, 1'b0, 1'b1);
        check("cs_good_ok_in_fill", csum_ok, 0);
        wait_fill("cs_good", 0, 1020);
        check("cs_good_csum", csum, 8'h00);
        check("cs_good_ok", csum_ok, 1);
        @(negedge clock);
        check("cs_good_ok_stable", csum_ok, 1);
        do_reload("rl5");
        img[3] = 8'hFB;
        load_image("cs_bad", 4, 1'b0, 1'b1);
        wait_fill("cs_bad", 0, 1020);
        check("cs_bad_csum", csum, 8'h01);
        check("cs_bad_ok", csum_ok, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
